eth_frame_former: RTL

ETH_FRAME_FORMER -- requirements
Module: eth_frame_former

---
 rtl/eth_frame_former.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/eth_frame_former.sv
// eth_frame_former
//   Reads one Ethernet frame (DA..payload, no FCS) from a byte RAM and sends it
//   on an MII (4-bit) or GMII (8-bit) transmit port: preamble + SFD, frame
//   bytes, optional zero pad up to 60 bytes, CRC-32 FCS, then the inter-frame gap.
//
//   Ports
//     clock      sole clock, rising edge
//     sclr       synchronous active-high reset; aborts a frame in flight
//     start      send request, taken only while busy=0
//     frame_len  frame length in bytes, captured on an accepted start
//     busy       high from accepted start until the end of the IFG
//     done       one-cycle pulse once the IFG has elapsed (busy=0 in that cycle)
//     ram_addr   RAM byte address
//     ram_rden   RAM read enable; data comes back one cycle later
//     ram_data   RAM read data
//     txd        transmit symbol (low nibble first in 4-bit mode)
//     tx_en      transmit enable
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; done pulses here for one cycle after IFG
//   PRE    | 7 x 0x55 preamble then 0xD5 SFD
//   DATA   | frame bytes from RAM, addresses 0..len-1
//   PAD    | 0x00 bytes until 60 bytes follow the SFD
//   FCS    | 4 CRC-32 bytes, least significant byte first
//   IFG    | tx_en=0, txd=0 for IFG_BYTES byte-times
module eth_frame_former #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 11,
    parameter int PAD_EN    = 1,
    parameter int IFG_BYTES = 12
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              start,
    input  logic [10:0]       frame_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [7:0]        ram_data,
    output logic [DATA_W-1:0] txd,
    output logic              tx_en
);

    localparam int NIB          = (DATA_W == 4) ? 1 : 0;
    localparam int SYM_PER_BYTE = 8 / DATA_W;
    localparam int IFG_CYC      = IFG_BYTES * SYM_PER_BYTE;
    // How many byte slots ahead of use a RAM read is issued: in 8-bit mode a
    // byte lasts one clock, so the read has to start two byte slots early.
    localparam int LEAD         = (NIB != 0) ? 1 : 2;

    localparam logic [11:0] PRE_BYTES = 12'd8;
    localparam logic [11:0] RD_LO     = 12'(8 - LEAD);
    localparam logic [10:0] MAX_LEN   = 11'd1514;
    localparam logic [10:0] MIN_BODY  = 11'd60;
    localparam logic [15:0] IFG_LOAD  = 16'(IFG_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] byte_cnt, byte_cnt_nxt;
    logic        phase, phase_nxt;
    logic [7:0]  cur_byte, cur_byte_nxt;
    logic [31:0] crc, crc_nxt;
    logic [15:0] ifg_cnt, ifg_cnt_nxt;
    logic [10:0] len_q, len_nxt;
    logic [10:0] body_q, body_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic        done_nxt;

    logic [10:0] len_clamp;
    logic [10:0] body_len;
    logic        accept;
    logic        tx_on;
    logic        sym_last;
    logic [11:0] next_pos;
    logic [11:0] data_end;
    logic [11:0] body_end;
    logic [11:0] fcs_end;
    logic [11:0] fcs_off;
    logic [31:0] crc_inv;
    logic [DATA_W-1:0] sym;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign len_clamp = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    assign body_len  = ((PAD_EN != 0) && (len_clamp < MIN_BODY)) ? MIN_BODY : len_clamp;
    assign accept    = start && (state == S_IDLE) && ((len_clamp != 11'd0) || (PAD_EN != 0));

    assign tx_on     = (state == S_PRE) || (state == S_DATA) || (state == S_PAD) || (state == S_FCS);
    assign sym_last  = (NIB != 0) ? phase : 1'b1;
    assign next_pos  = byte_cnt + 12'd1;
    assign data_end  = PRE_BYTES + {1'b0, len_q};
    assign body_end  = PRE_BYTES + {1'b0, body_q};
    assign fcs_end   = body_end + 12'd4;
    assign fcs_off   = next_pos - body_end;
    assign crc_inv   = ~crc;

    // A read is issued only in the cycle whose data will be loaded into
    // cur_byte at the next byte boundary, so every read is consumed.
    assign ram_rden  = ((state == S_PRE) || (state == S_DATA))
                     && ((NIB != 0) ? !phase : 1'b1)
                     && (byte_cnt >= RD_LO)
                     && (byte_cnt < RD_LO + {1'b0, len_q});

    generate
        if (DATA_W == 8) begin : g_byte
            assign sym = cur_byte[DATA_W-1:0];
        end else begin : g_nib
            assign sym = phase ? cur_byte[7:4] : cur_byte[3:0];
        end
    endgenerate

    assign busy  = (state != S_IDLE);
    assign tx_en = tx_on;
    assign txd   = tx_on ? sym : '0;

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        phase_nxt    = phase;
        cur_byte_nxt = cur_byte;
        crc_nxt      = crc;
        ifg_cnt_nxt  = ifg_cnt;
        len_nxt      = len_q;
        body_nxt     = body_q;
        addr_nxt     = ram_rden ? (ram_addr + 1'b1) : ram_addr;
        done_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt    = S_PRE;
                    byte_cnt_nxt = '0;
                    phase_nxt    = 1'b0;
                    cur_byte_nxt = 8'h55;
                    crc_nxt      = '1;
                    len_nxt      = len_clamp;
                    body_nxt     = body_len;
                    addr_nxt     = '0;
                end
            end

            S_PRE, S_DATA, S_PAD, S_FCS: begin
                if (!sym_last) begin
                    phase_nxt = 1'b1;
                end else begin
                    // Byte boundary: choose the next byte by its position
                    // counted from the first preamble byte.
                    phase_nxt    = 1'b0;
                    byte_cnt_nxt = next_pos;
                    if (next_pos < 12'd7) begin
                        cur_byte_nxt = 8'h55;
                    end else if (next_pos == 12'd7) begin
                        cur_byte_nxt = 8'hD5;
                    end else if (next_pos < data_end) begin
                        state_nxt    = S_DATA;
                        cur_byte_nxt = ram_data;
                        crc_nxt      = crc_byte(crc, ram_data);
                    end else if (next_pos < body_end) begin
                        state_nxt    = S_PAD;
                        cur_byte_nxt = 8'h00;
                        crc_nxt      = crc_byte(crc, 8'h00);
                    end else if (next_pos < fcs_end) begin
                        state_nxt = S_FCS;
                        case (fcs_off[1:0])
                            2'd0:    cur_byte_nxt = crc_inv[7:0];
                            2'd1:    cur_byte_nxt = crc_inv[15:8];
                            2'd2:    cur_byte_nxt = crc_inv[23:16];
                            default: cur_byte_nxt = crc_inv[31:24];
                        endcase
                    end else begin
                        state_nxt    = S_IFG;
                        cur_byte_nxt = 8'h00;
                        ifg_cnt_nxt  = IFG_LOAD;
                    end
                end
            end

            S_IFG: begin
                if (ifg_cnt == 16'd0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    ifg_cnt_nxt = ifg_cnt - 16'd1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
            phase    <= 1'b0;
            cur_byte <= '0;
            crc      <= '1;
            ifg_cnt  <= '0;
            len_q    <= '0;
            body_q   <= '0;
            ram_addr <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            phase    <= phase_nxt;
            cur_byte <= cur_byte_nxt;
            crc      <= crc_nxt;
            ifg_cnt  <= ifg_cnt_nxt;
            len_q    <= len_nxt;
            body_q   <= body_nxt;
            ram_addr <= addr_nxt;
            done     <= done_nxt;
        end
    end

endmodule
